id_issue_ctrl: RTL and testbench
================================

# id_issue_ctrl

Issue controller for the ID stage of the in-order LoongArch32 pipeline. It sits beside the decode stage and decides each cycle whether the decoded instruction may issue into EX. It keeps a per-register pending-write scoreboard, stalls IF/ID on RAW hazards and on WAW overflow, and sequences the fixed-latency divider (DIV/MOD) by freezing EX while it runs. It also raises the IF flush for taken branches and jumps, but only when that instruction actually issues.

## Interface
Parameters:
- DIV_CYCLES, default 32: number of cycles EX is held for DIV.W/MOD.W/DIV.WU/MOD.WU; legal range 1..63.
- SB_MAX, default 3: maximum in-flight writes per register (EX+MEM+WB).

Ports (clock and reset first):
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- id_valid  in  1  ID holds a valid decoded instruction.
- id_r1_en, id_r2_en  in  1 each  source read enables.
- id_r1_addr, id_r2_addr  in  5 each  source register numbers.
- id_rw_en  in  1  instruction writes a register.
- id_rw_addr  in  5  destination register.
- id_is_div  in  1  instruction uses the divider.
- id_redirect  in  1  branch_en | jump_en from decode.
- wb_rw_en  in  1  WB retires a register write this cycle.
- wb_rw_addr  in  5  register retired.
- issue  out  1  instruction moves ID→EX at this edge.
- id_stall  out  1  hold the IF/ID register and PC.
- ex_bubble  out  1  load a NOP into ID/EX.
- if_flush  out  1  kill the instruction in IF/ID.
- ex_hold  out  1  freeze the ID/EX register and EX.
- div_start  out  1  one-cycle divider start pulse.
- sb_underflow  out  1  sticky error: retire to a register with count 0.
- stall_cnt  out  32  number of cycles with id_stall=1; wraps.

## Operation
- Scoreboard: cnt[r] has width clog2(SB_MAX+1) for r=1..31. r0 is never tracked and always reads 0.
- hazard = (r1_en & r1_addr≠0 & cnt[r1_addr]≠0) | (r2_en & r2_addr≠0 & cnt[r2_addr]≠0) | (rw_en & rw_addr≠0 & cnt[rw_addr]==SB_MAX).
- issue = id_valid & ~hazard & state==IDLE.
- id_stall = id_valid & ~issue.
- ex_bubble = ~issue & state==IDLE.
- if_flush = issue & id_redirect. A redirect seen while stalled is ignored, because its operands may be stale.
- On issue with rw_en & rw_addr≠0: cnt[rw_addr] increments.
- On wb_rw_en & wb_rw_addr≠0: cnt[wb_rw_addr] decrements.
- If the same register is issued and retired in the same cycle, its count is unchanged.
- If a retire targets a register whose count is 0, the count holds at 0 and sb_underflow sets. sb_underflow clears only on rst.
- Divider FSM has two states, IDLE and BUSY:
  - IDLE→BUSY when issue & id_is_div. In that cycle div_start=1 and the down-counter loads DIV_CYCLES-1.
  - In BUSY: ex_hold=1, ex_bubble=0, and id_stall=id_valid. The counter decrements each cycle; BUSY→IDLE when it reads 0.
  - WB retires continue normally during BUSY.
- stall_cnt increments in every cycle where id_stall=1.

## Timing
- All outputs except stall_cnt, sb_underflow and state are combinational from current inputs plus registered state. Scoreboard updates take effect at the next edge.
- RAW latency: a consumer issues in the cycle after its producer's WB retire. A same-cycle retire does not unblock a read.
- Divider: div_start is asserted in cycle t. ex_hold is high for cycles t+1..t+DIV_CYCLES. The first new issue is possible at t+DIV_CYCLES+1.
- Reset: all cnt=0, state=IDLE, stall_cnt=0, sb_underflow=0. With id_valid=0 the outputs are: issue=0, id_stall=0, ex_bubble=1, if_flush=0, ex_hold=0, div_start=0.
- Reset in BUSY returns to IDLE at the next edge, and ex_hold drops in the same cycle.

## Structure
- Package id_issue_pkg holds:
  - the divider state enum {IDLE, BUSY};
  - SB_CNT_W;
  - the REG_ZERO constant.
- Sub-module reg_scoreboard holds the 31 counters. It has an issue port (en, addr), a retire port (en, addr), three combinational lookup ports, and the underflow flag.
- id_issue_ctrl contains the hazard logic, the divider FSM/counter, and the stall counter.

## Test plan
- Issue `add r5` (rw), then `add r6,r5,r7` on the next cycle → cnt[5]=1, and the second instruction sees id_stall=1 and ex_bubble=1 until the cycle after a wb retire of r5, then issue=1.
- Four back-to-back writes to r4 with no retire → the first three issue, and the fourth has id_stall=1 until one retire; cnt[4] never exceeds 3.
- id_is_div issue with DIV_CYCLES=32 → div_start for 1 cycle and ex_hold for exactly 32 cycles. A valid instruction behind it stalls for 32 cycles and issues in cycle 33.
- Branch with id_redirect=1 and its source pending → if_flush=0 while stalled. if_flush=1 only in the issue cycle.
- wb_rw_en to r9 with cnt[9]=0 → sb_underflow=1 and stays set; cnt[9]=0. Writes and retires to r0 leave all counters unchanged.
- rst asserted in the middle of BUSY, with counters nonzero → the next cycle shows state IDLE, ex_hold=0, all cnt=0, and stall_cnt=0.

Source files
------------

// File: rtl/id_issue_pkg.sv
// Shared types and constants for the ID-stage issue controller.
package id_issue_pkg;

   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} div_state_e;

   localparam int         SB_MAX_DEF = 3;
   localparam logic [4:0] REG_ZERO   = 5'd0;

   function automatic int sb_cnt_w(input int max_cnt);
      return $clog2(max_cnt + 1);
   endfunction

   localparam int SB_CNT_W = sb_cnt_w(SB_MAX_DEF);

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register pending-write counters with one issue port, one retire port,
// three combinational lookups and a sticky underflow flag.
module reg_scoreboard
   import id_issue_pkg::*;
#(
   parameter int SB_MAX = SB_MAX_DEF,
   parameter int CW     = sb_cnt_w(SB_MAX)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          iss_en,
   input  logic [4:0]    iss_addr,
   input  logic          ret_en,
   input  logic [4:0]    ret_addr,
   input  logic [4:0]    lk1_addr,
   input  logic [4:0]    lk2_addr,
   input  logic [4:0]    lk3_addr,
   output logic [CW-1:0] lk1_cnt,
   output logic [CW-1:0] lk2_cnt,
   output logic [CW-1:0] lk3_cnt,
   output logic          underflow
);

   localparam logic [CW-1:0] MAXC = CW'(SB_MAX);

   logic [CW-1:0] cnt_q [0:31];
   logic [31:0]   inc_v, dec_v, uf_v;
   logic          uf_q;

   assign inc_v = (iss_en && iss_addr != REG_ZERO) ? (32'd1 << iss_addr) : 32'd0;
   assign dec_v = (ret_en && ret_addr != REG_ZERO) ? (32'd1 << ret_addr) : 32'd0;

   // A retire paired with a same-cycle issue cancels out and is not an underflow.
   always_comb begin
      uf_v = '0;
      for (int r = 1; r < 32; r++)
         uf_v[r] = dec_v[r] & ~inc_v[r] & (cnt_q[r] == '0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int r = 0; r < 32; r++) cnt_q[r] <= '0;
         uf_q <= 1'b0;
      end else begin
         for (int r = 1; r < 32; r++) begin
            if (inc_v[r] && !dec_v[r] && cnt_q[r] != MAXC)
               cnt_q[r] <= cnt_q[r] + 1'b1;
            else if (dec_v[r] && !inc_v[r] && cnt_q[r] != '0)
               cnt_q[r] <= cnt_q[r] - 1'b1;
         end
         if (|uf_v) uf_q <= 1'b1;
      end
   end

   assign lk1_cnt   = (lk1_addr == REG_ZERO) ? '0 : cnt_q[lk1_addr];
   assign lk2_cnt   = (lk2_addr == REG_ZERO) ? '0 : cnt_q[lk2_addr];
   assign lk3_cnt   = (lk3_addr == REG_ZERO) ? '0 : cnt_q[lk3_addr];
   assign underflow = uf_q;

endmodule

// File: rtl/id_issue_ctrl.sv
// ID-stage issue decision: RAW/WAW hazard stalls, divider sequencing that
// freezes EX, branch flush gating and a stall-cycle counter.
module id_issue_ctrl
   import id_issue_pkg::*;
#(
   parameter int DIV_CYCLES = 32,
   parameter int SB_MAX     = SB_MAX_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        id_valid,
   input  logic        id_r1_en,
   input  logic        id_r2_en,
   input  logic [4:0]  id_r1_addr,
   input  logic [4:0]  id_r2_addr,
   input  logic        id_rw_en,
   input  logic [4:0]  id_rw_addr,
   input  logic        id_is_div,
   input  logic        id_redirect,
   input  logic        wb_rw_en,
   input  logic [4:0]  wb_rw_addr,
   output logic        issue,
   output logic        id_stall,
   output logic        ex_bubble,
   output logic        if_flush,
   output logic        ex_hold,
   output logic        div_start,
   output logic        sb_underflow,
   output logic [31:0] stall_cnt
);

   localparam int            CW    = sb_cnt_w(SB_MAX);
   localparam logic [CW-1:0] MAXC  = CW'(SB_MAX);
   localparam int            DW    = 6;
   localparam logic [DW-1:0] DLOAD = DW'(DIV_CYCLES - 1);

   div_state_e    state_q;
   logic [DW-1:0] div_cnt_q;
   logic [31:0]   stall_cnt_q;
   logic [CW-1:0] r1_cnt, r2_cnt, rw_cnt;
   logic          hazard, idle;

   reg_scoreboard #(.SB_MAX(SB_MAX), .CW(CW)) u_sb (
      .clk       (clk),
      .rst       (rst),
      .iss_en    (issue & id_rw_en),
      .iss_addr  (id_rw_addr),
      .ret_en    (wb_rw_en),
      .ret_addr  (wb_rw_addr),
      .lk1_addr  (id_r1_addr),
      .lk2_addr  (id_r2_addr),
      .lk3_addr  (id_rw_addr),
      .lk1_cnt   (r1_cnt),
      .lk2_cnt   (r2_cnt),
      .lk3_cnt   (rw_cnt),
      .underflow (sb_underflow)
   );

   // r0 lookups already return zero, so the address checks are implicit.
   assign hazard = (id_r1_en && r1_cnt != '0) ||
                   (id_r2_en && r2_cnt != '0) ||
                   (id_rw_en && rw_cnt == MAXC);

   assign idle      = (state_q == IDLE);
   assign issue     = id_valid & ~hazard & idle;
   assign id_stall  = id_valid & ~issue;
   assign ex_bubble = ~issue & idle;
   assign if_flush  = issue & id_redirect;
   assign ex_hold   = ~idle;
   assign div_start = issue & id_is_div;
   assign stall_cnt = stall_cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         div_cnt_q   <= '0;
         stall_cnt_q <= '0;
      end else begin
         if (id_stall) stall_cnt_q <= stall_cnt_q + 32'd1;
         case (state_q)
            IDLE: if (div_start) begin
               state_q   <= BUSY;
               div_cnt_q <= DLOAD;
            end
            BUSY: begin
               if (div_cnt_q == '0) state_q <= IDLE;
               else                 div_cnt_q <= div_cnt_q - 1'b1;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_id_issue_ctrl.sv
// Directed bench for id_issue_ctrl: hazards, WAW limit, divider hold,
// flush gating, underflow and reset during BUSY.
module tb_id_issue_ctrl;
   import id_issue_pkg::*;

   logic        clk, rst;
   logic        id_valid, id_r1_en, id_r2_en, id_rw_en, id_is_div, id_redirect;
   logic [4:0]  id_r1_addr, id_r2_addr, id_rw_addr;
   logic        wb_rw_en;
   logic [4:0]  wb_rw_addr;
   logic        issue, id_stall, ex_bubble, if_flush, ex_hold, div_start, sb_underflow;
   logic [31:0] stall_cnt;

   int errors = 0;
   int checks = 0;
   int exp_stall = 0;

   id_issue_ctrl #(.DIV_CYCLES(32), .SB_MAX(3)) dut (
      .clk(clk), .rst(rst), .id_valid(id_valid),
      .id_r1_en(id_r1_en), .id_r2_en(id_r2_en),
      .id_r1_addr(id_r1_addr), .id_r2_addr(id_r2_addr),
      .id_rw_en(id_rw_en), .id_rw_addr(id_rw_addr),
      .id_is_div(id_is_div), .id_redirect(id_redirect),
      .wb_rw_en(wb_rw_en), .wb_rw_addr(wb_rw_addr),
      .issue(issue), .id_stall(id_stall), .ex_bubble(ex_bubble),
      .if_flush(if_flush), .ex_hold(ex_hold), .div_start(div_start),
      .sb_underflow(sb_underflow), .stall_cnt(stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_in;
      id_valid = 0; id_r1_en = 0; id_r2_en = 0; id_rw_en = 0;
      id_r1_addr = 0; id_r2_addr = 0; id_rw_addr = 0;
      id_is_div = 0; id_redirect = 0; wb_rw_en = 0; wb_rw_addr = 0;
   endtask

   task automatic test_reset;
      idle_in();
      rst = 1;
      tick(); tick();
      rst = 0;
      #4;
      checks++; if (issue !== 1'b0) begin errors++; $display("FAIL rst_issue got=%0b exp=0", issue); end
      checks++; if (id_stall !== 1'b0) begin errors++; $display("FAIL rst_stall got=%0b exp=0", id_stall); end
      checks++; if (ex_bubble !== 1'b1) begin errors++; $display("FAIL rst_bubble got=%0b exp=1", ex_bubble); end
      checks++; if ({if_flush, ex_hold, div_start} !== 3'b000) begin errors++; $display("FAIL rst_flush_hold_start got=%03b exp=000", {if_flush, ex_hold, div_start}); end
      checks++; if (stall_cnt !== 32'd0) begin errors++; $display("FAIL rst_stall_cnt got=%0d exp=0", stall_cnt); end
      checks++; if (sb_underflow !== 1'b0) begin errors++; $display("FAIL rst_underflow got=%0b exp=0", sb_underflow); end
      tick();
   endtask

   task automatic test_raw;
      idle_in();
      id_valid = 1; id_rw_en = 1; id_rw_addr = 5;
      #4;
      checks++; if ({issue, ex_bubble, if_flush} !== 3'b100) begin errors++; $display("FAIL raw_prod got=%03b exp=100", {issue, ex_bubble, if_flush}); end
      tick();
      checks++; if (dut.u_sb.cnt_q[5] !== 2'd1) begin errors++; $display("FAIL raw_cnt5 got=%0d exp=1", dut.u_sb.cnt_q[5]); end
      id_r1_en = 1; id_r1_addr = 5; id_r2_en = 1; id_r2_addr = 7; id_rw_addr = 6;
      for (int i = 0; i < 3; i++) begin
         #4;
         checks++; if ({issue, id_stall, ex_bubble} !== 3'b011) begin errors++; $display("FAIL raw_stall%0d got=%03b exp=011", i, {issue, id_stall, ex_bubble}); end
         tick();
      end
      wb_rw_en = 1; wb_rw_addr = 5;
      #4;
      checks++; if ({issue, id_stall} !== 2'b01) begin errors++; $display("FAIL raw_same_cycle_wb got=%02b exp=01", {issue, id_stall}); end
      tick();
      exp_stall += 4;
      wb_rw_en = 0;
      #4;
      checks++; if ({issue, id_stall, ex_bubble} !== 3'b100) begin errors++; $display("FAIL raw_issue got=%03b exp=100", {issue, id_stall, ex_bubble}); end
      tick();
      idle_in();
      wb_rw_en = 1; wb_rw_addr = 6;
      tick();
      wb_rw_en = 0;
      checks++; if ({dut.u_sb.cnt_q[5], dut.u_sb.cnt_q[6]} !== 4'd0) begin errors++; $display("FAIL raw_cleanup got=%0d/%0d exp=0/0", dut.u_sb.cnt_q[5], dut.u_sb.cnt_q[6]); end
      checks++; if (stall_cnt !== 32'(exp_stall)) begin errors++; $display("FAIL raw_stall_cnt got=%0d exp=%0d", stall_cnt, exp_stall); end
   endtask

   task automatic test_waw;
      idle_in();
      id_valid = 1; id_rw_en = 1; id_rw_addr = 4;
      for (int i = 0; i < 3; i++) begin
         #4;
         checks++; if (issue !== 1'b1) begin errors++; $display("FAIL waw_issue%0d got=%0b exp=1", i, issue); end
         tick();
      end
      checks++; if (dut.u_sb.cnt_q[4] !== 2'd3) begin errors++; $display("FAIL waw_cnt_full got=%0d exp=3", dut.u_sb.cnt_q[4]); end
      for (int i = 0; i < 3; i++) begin
         if (i == 2) begin wb_rw_en = 1; wb_rw_addr = 4; end
         #4;
         checks++; if ({issue, id_stall} !== 2'b01) begin errors++; $display("FAIL waw_stall%0d got=%02b exp=01", i, {issue, id_stall}); end
         tick();
      end
      exp_stall += 3;
      wb_rw_en = 0;
      #4;
      checks++; if (issue !== 1'b1) begin errors++; $display("FAIL waw_after_retire got=%0b exp=1", issue); end
      tick();
      checks++; if (dut.u_sb.cnt_q[4] !== 2'd3) begin errors++; $display("FAIL waw_cnt_refill got=%0d exp=3", dut.u_sb.cnt_q[4]); end
      idle_in();
      wb_rw_en = 1; wb_rw_addr = 4;
      tick(); tick(); tick();
      wb_rw_en = 0;
      checks++; if (dut.u_sb.cnt_q[4] !== 2'd0) begin errors++; $display("FAIL waw_drain got=%0d exp=0", dut.u_sb.cnt_q[4]); end
   endtask

   task automatic test_div;
      int bad;
      idle_in();
      id_valid = 1; id_is_div = 1; id_rw_en = 1; id_rw_addr = 8;
      #4;
      checks++; if ({issue, div_start, ex_hold} !== 3'b110) begin errors++; $display("FAIL div_start got=%03b exp=110", {issue, div_start, ex_hold}); end
      tick();
      id_is_div = 0; id_rw_addr = 10;
      bad = 0;
      for (int i = 1; i <= 32; i++) begin
         wb_rw_en = (i == 5); wb_rw_addr = 8;
         #4;
         if ({ex_hold, issue, id_stall, ex_bubble, div_start} !== 5'b10100) begin
            bad++;
            $display("FAIL div_busy_cycle%0d got=%05b exp=10100", i, {ex_hold, issue, id_stall, ex_bubble, div_start});
         end
         tick();
      end
      checks++; if (bad != 0) errors++;
      exp_stall += 32;
      wb_rw_en = 0;
      checks++; if (dut.u_sb.cnt_q[8] !== 2'd0) begin errors++; $display("FAIL div_wb_in_busy got=%0d exp=0", dut.u_sb.cnt_q[8]); end
      #4;
      checks++; if ({ex_hold, issue} !== 2'b01) begin errors++; $display("FAIL div_release got=%02b exp=01", {ex_hold, issue}); end
      tick();
      idle_in();
      wb_rw_en = 1; wb_rw_addr = 10;
      tick();
      wb_rw_en = 0;
      checks++; if (stall_cnt !== 32'(exp_stall)) begin errors++; $display("FAIL div_stall_cnt got=%0d exp=%0d", stall_cnt, exp_stall); end
   endtask

   task automatic test_redirect;
      idle_in();
      id_valid = 1; id_rw_en = 1; id_rw_addr = 3;
      tick();
      id_rw_en = 0; id_r1_en = 1; id_r1_addr = 3; id_redirect = 1;
      for (int i = 0; i < 3; i++) begin
         if (i == 2) begin wb_rw_en = 1; wb_rw_addr = 3; end
         #4;
         checks++; if ({if_flush, id_stall} !== 2'b01) begin errors++; $display("FAIL br_stalled%0d got=%02b exp=01", i, {if_flush, id_stall}); end
         tick();
      end
      exp_stall += 3;
      wb_rw_en = 0;
      #4;
      checks++; if ({issue, if_flush} !== 2'b11) begin errors++; $display("FAIL br_flush got=%02b exp=11", {issue, if_flush}); end
      tick();
      id_valid = 0;
      #4;
      checks++; if (if_flush !== 1'b0) begin errors++; $display("FAIL br_no_valid got=%0b exp=0", if_flush); end
      tick();
      idle_in();
   endtask

   task automatic test_underflow;
      int nz;
      idle_in();
      wb_rw_en = 1; wb_rw_addr = 0;
      tick();
      checks++; if (sb_underflow !== 1'b0) begin errors++; $display("FAIL uf_r0_retire got=%0b exp=0", sb_underflow); end
      id_valid = 1; id_rw_en = 1; id_rw_addr = 0;
      #4;
      checks++; if (issue !== 1'b1) begin errors++; $display("FAIL uf_r0_issue got=%0b exp=1", issue); end
      tick();
      idle_in();
      nz = 0;
      for (int r = 0; r < 32; r++) if (dut.u_sb.cnt_q[r] !== 2'd0) nz++;
      checks++; if (nz != 0) begin errors++; $display("FAIL uf_r0_counters got=%0d nonzero exp=0", nz); end
      wb_rw_en = 1; wb_rw_addr = 9;
      tick();
      wb_rw_en = 0;
      checks++; if (sb_underflow !== 1'b1) begin errors++; $display("FAIL uf_set got=%0b exp=1", sb_underflow); end
      checks++; if (dut.u_sb.cnt_q[9] !== 2'd0) begin errors++; $display("FAIL uf_cnt9 got=%0d exp=0", dut.u_sb.cnt_q[9]); end
      tick(); tick(); tick();
      checks++; if (sb_underflow !== 1'b1) begin errors++; $display("FAIL uf_sticky got=%0b exp=1", sb_underflow); end
      checks++; if (stall_cnt !== 32'(exp_stall)) begin errors++; $display("FAIL uf_stall_cnt got=%0d exp=%0d", stall_cnt, exp_stall); end
   endtask

   task automatic test_reset_busy;
      int nz;
      idle_in();
      id_valid = 1; id_rw_en = 1; id_rw_addr = 12;
      tick();
      id_is_div = 1; id_rw_addr = 13;
      #4;
      checks++; if (div_start !== 1'b1) begin errors++; $display("FAIL rb_div_start got=%0b exp=1", div_start); end
      tick();
      idle_in();
      tick(); tick(); tick();
      #4;
      checks++; if ({ex_hold, dut.state_q} !== {1'b1, BUSY}) begin errors++; $display("FAIL rb_busy got=%02b exp=11", {ex_hold, dut.state_q}); end
      checks++; if (dut.u_sb.cnt_q[12] !== 2'd1) begin errors++; $display("FAIL rb_cnt12 got=%0d exp=1", dut.u_sb.cnt_q[12]); end
      rst = 1;
      tick();
      rst = 0;
      exp_stall = 0;
      #4;
      checks++; if ({ex_hold, dut.state_q} !== {1'b0, IDLE}) begin errors++; $display("FAIL rb_idle got=%02b exp=00", {ex_hold, dut.state_q}); end
      checks++; if (stall_cnt !== 32'd0) begin errors++; $display("FAIL rb_stall_cnt got=%0d exp=0", stall_cnt); end
      checks++; if (sb_underflow !== 1'b0) begin errors++; $display("FAIL rb_underflow got=%0b exp=0", sb_underflow); end
      nz = 0;
      for (int r = 0; r < 32; r++) if (dut.u_sb.cnt_q[r] !== 2'd0) nz++;
      checks++; if (nz != 0) begin errors++; $display("FAIL rb_counters got=%0d nonzero exp=0", nz); end
      tick();
   endtask

   initial begin
      idle_in();
      rst = 1;
      test_reset();
      test_raw();
      test_waw();
      test_div();
      test_redirect();
      test_underflow();
      test_reset_busy();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
